// File: rtl/note_scheduler.sv
// note_scheduler
//
// Shares the single tone generator among the seven note keys (Do..Si).
// Raw keys are synchronised, debounced per key, then arbitrated so the most
// recent press sounds. Divisor changes while a note is sounding are held in a
// pending register and applied only on the generator's half-period `tick`,
// so the speaker waveform never glitches.
//
// Ports
//   clk          50 MHz system clock
//   rst_n        asynchronous active-low reset
//   key_in       raw asynchronous active-high keys, bit 0 = Do (C4), bit 6 = Si (B4)
//   tick         one-cycle strobe from the generator on each speaker toggle
//   half_period  19-bit terminal count loaded into the generator
//   tone_en      generator enable (speaker held low while 0)
//   note_idx     index of the sounding note, 0..6
//   busy         high whenever the controller is not IDLE
//
// Parameters
//   NUM_KEYS        number of keys; the divisor table covers exactly 7
//   DEB_CYCLES      consecutive stable cycles before a debounced level changes
//   SUSTAIN_CYCLES  hold time after the last release (sustain build only)
//
// Build option
//   NOTE_SUSTAIN_EN  when defined, the release state keeps tone_en high for
//                    SUSTAIN_CYCLES cycles before stopping on the next tick.
//
// Strobe semantics: `tick` is a single-cycle pulse with no back-pressure; a
// note change or stop waits for it indefinitely.
module note_scheduler #(
  parameter int NUM_KEYS       = 7,
  parameter int DEB_CYCLES     = 500000,
  parameter int SUSTAIN_CYCLES = 12500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                tick,
  output logic [18:0]         half_period,
  output logic                tone_en,
  output logic [2:0]          note_idx,
  output logic                busy
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAY    = 2'd1;
  // Plain release, or sustain when NOTE_SUSTAIN_EN is defined.
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Elaboration-time guard: the divisor table only exists for seven keys.
  if (NUM_KEYS != 7 || DEB_CYCLES < 1 || SUSTAIN_CYCLES < 1) begin : g_bad_cfg
    $error("note_scheduler: unsupported parameter set");
  end

`ifdef NOTE_SUSTAIN_EN
  localparam int SUS_W = $clog2(SUSTAIN_CYCLES + 1);
  localparam logic [SUS_W-1:0] SUS_END = SUS_W'(SUSTAIN_CYCLES);
  logic [SUS_W-1:0] sus_cnt;
`endif

  logic [NUM_KEYS-1:0] sync1, sync2, key_db, key_db_q;
  logic [DEB_W-1:0]    deb_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] rise, fall;
  logic                cand_valid;
  logic [2:0]          cand_idx;
  logic                pend_valid;
  logic [2:0]          pend_idx;
  logic [1:0]          state;

  function automatic logic [18:0] divisor(input logic [2:0] idx);
    case (idx)
      3'd0:    divisor = 19'd95555;
      3'd1:    divisor = 19'd85130;
      3'd2:    divisor = 19'd75842;
      3'd3:    divisor = 19'd71586;
      3'd4:    divisor = 19'd63775;
      3'd5:    divisor = 19'd56817;
      3'd6:    divisor = 19'd50619;
      default: divisor = 19'd0;
    endcase
  endfunction

  // Index of the lowest set bit (0 if none); scanning downwards lets the
  // lowest index overwrite any higher one.
  function automatic logic [2:0] lowest(input logic [NUM_KEYS-1:0] v);
    lowest = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  // Synchronisers and per-key debounce counters. The counter runs only while
  // the synchronised level disagrees with the debounced one; any agreement
  // (a bounce back) restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      key_db   <= '0;
      key_db_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= key_in;
      sync2    <= sync1;
      key_db_q <= key_db;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2[i] != key_db[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            key_db[i]  <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = key_db & ~key_db_q;
  assign fall = key_db_q & ~key_db;

  // Candidate: a fresh press always wins (lowest index on a tie); otherwise,
  // losing the sounding key hands the tone to the lowest key still held.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    if (|rise) begin
      cand_valid = 1'b1;
      cand_idx   = lowest(rise);
    end else if (state != ST_IDLE && fall[note_idx] && |key_db) begin
      cand_valid = 1'b1;
      cand_idx   = lowest(key_db);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      half_period <= '0;
      note_idx    <= '0;
      tone_en     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_idx    <= '0;
`ifdef NOTE_SUSTAIN_EN
      sus_cnt     <= '0;
`endif
    end else begin
      // Pending-change rule while the generator is running. A candidate in
      // the tick cycle itself is applied directly; a re-press of the sounding
      // key cancels any queued change.
      if (state == ST_PLAY || state == ST_RELEASE) begin
        if (tick) begin
          if (cand_valid) begin
            if (cand_idx != note_idx) begin
              half_period <= divisor(cand_idx);
              note_idx    <= cand_idx;
            end
          end else if (pend_valid) begin
            half_period <= divisor(pend_idx);
            note_idx    <= pend_idx;
          end
          pend_valid <= 1'b0;
        end else if (cand_valid) begin
          pend_valid <= (cand_idx != note_idx);
          pend_idx   <= cand_idx;
        end
      end

      case (state)
        ST_IDLE: begin
          pend_valid <= 1'b0;
          // Generator is stopped, so the divisor can be loaded at once;
          // tone_en follows one cycle later from PLAY.
          if (cand_valid) begin
            half_period <= divisor(cand_idx);
            note_idx    <= cand_idx;
            state       <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          tone_en <= 1'b1;
`ifdef NOTE_SUSTAIN_EN
          sus_cnt <= '0;
`endif
          if (key_db == '0) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
`ifdef NOTE_SUSTAIN_EN
          if (|key_db) begin
            state   <= ST_PLAY;
            sus_cnt <= '0;
          end else if (sus_cnt != SUS_END) begin
            sus_cnt <= sus_cnt + SUS_W'(1);
          end else if (tick) begin
            tone_en    <= 1'b0;
            state      <= ST_IDLE;
            pend_valid <= 1'b0;
            sus_cnt    <= '0;
          end
`else
          if (|key_db) begin
            state <= ST_PLAY;
          end else if (tick) begin
            tone_en    <= 1'b0;
            state      <= ST_IDLE;
            pend_valid <= 1'b0;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
